// File: rtl/otg_bus_responder_pkg.sv
// Shared types and constants for the OTG parallel-bus responder.
// State encodings, bus bit positions and the error read value.
package otg_bus_responder_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_RD_LO = 3'd2,
    S_RD_HI = 3'd3,
    S_WR_LO = 3'd4,
    S_WR_HI = 3'd5
  } state_t;

  localparam int CMD_DIR_BIT   = 7;
  localparam int ADDR_CMD_BIT  = 0;
  localparam int ADDR_UNIT_BIT = 1;

  localparam logic [15:0] ERR_RDATA = 16'hFFFF;

  function automatic logic is_wide(
    input logic [6:0] idx,
    input logic [6:0] lim
  );
    return idx < lim;
  endfunction

endpackage

// File: rtl/otg_bus_responder_if.sv
// OTG 16-bit parallel bus pins as seen by initiator and responder.
// Strobes are active-low and asynchronous to the responder clock.
interface otg_bus_responder_if;

  logic        otg_cs_n;
  logic        otg_rd_n;
  logic        otg_wr_n;
  logic [1:0]  otg_addr;
  logic [15:0] otg_data_in;
  logic [15:0] otg_data_out;
  logic        otg_data_oe;

  modport master (
    output otg_cs_n,
    output otg_rd_n,
    output otg_wr_n,
    output otg_addr,
    output otg_data_in,
    input  otg_data_out,
    input  otg_data_oe
  );

  modport slave (
    input  otg_cs_n,
    input  otg_rd_n,
    input  otg_wr_n,
    input  otg_addr,
    input  otg_data_in,
    output otg_data_out,
    output otg_data_oe
  );

endinterface

// File: rtl/otg_strobe_sync.sv
// Brings the bus strobes into the clk domain and derives
// read/write activity plus their edge pulses.
module otg_strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic cs_n,
  input  logic rd_n,
  input  logic wr_n,
  output logic wr_act,
  output logic rd_rise,
  output logic rd_fall,
  output logic wr_fall,
  output logic conflict
);

  logic [1:0] cs_ff;
  logic [1:0] rd_ff;
  logic [1:0] wr_ff;
  logic       rd_act;
  logic       both;
  logic       rd_q;
  logic       wr_q;
  logic       both_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_ff  <= 2'b11;
      rd_ff  <= 2'b11;
      wr_ff  <= 2'b11;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      both_q <= 1'b0;
    end else begin
      cs_ff  <= {cs_ff[0], cs_n};
      rd_ff  <= {rd_ff[0], rd_n};
      wr_ff  <= {wr_ff[0], wr_n};
      rd_q   <= rd_act;
      wr_q   <= wr_act;
      both_q <= both;
    end
  end

  // Both strobes low at once: neither side acts.
  assign both     = ~cs_ff[1] & ~rd_ff[1] & ~wr_ff[1];
  assign rd_act   = ~cs_ff[1] & ~rd_ff[1] & wr_ff[1];
  assign wr_act   = ~cs_ff[1] & ~wr_ff[1] & rd_ff[1];
  assign rd_rise  = rd_act & ~rd_q;
  assign rd_fall  = ~rd_act & rd_q;
  assign wr_fall  = ~wr_act & wr_q;
  assign conflict = both & ~both_q;

endmodule

// File: rtl/otg_bus_responder.sv
// Responder side of the ISP1362-style OTG bus: turns command/data
// port cycles into single-cycle local register reads and writes.
module otg_bus_responder
  import otg_bus_responder_pkg::*;
#(
  parameter logic [6:0]  WIDE_LIMIT     = 7'h20,
  parameter logic [15:0] CHIP_ID        = 16'h3630,
  parameter bit          INT_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  otg_bus_responder_if.slave bus,
  output logic               otg_int0,
  output logic               otg_int1,
  output logic               reg_unit,
  output logic [6:0]         reg_index,
  output logic               reg_we,
  output logic [31:0]        reg_wdata,
  output logic               reg_re,
  input  logic [31:0]        reg_rdata,
  input  logic               reg_rvalid,
  input  logic               irq_hc,
  input  logic               irq_dc,
  output logic               err
);

  state_t      state_q, state_d;
  logic        unit_q, unit_d;
  logic [6:0]  index_q, index_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        re_q, re_d;
  logic        err_q, err_d;
  logic [15:0] dout_q, dout_d;
  logic        oe_q, oe_d;
  logic [1:0]  cap_addr_q, cap_addr_d;
  logic [15:0] cap_data_q, cap_data_d;
  logic        rd_ok_q, rd_ok_d;
  logic        int0_q, int1_q;

  logic wr_act;
  logic rd_rise;
  logic rd_fall;
  logic wr_fall;
  logic conflict;

  logic wide;
  logic rd_cmd;
  logic rd_good;
  logic rd_bad;
  logic rd_in_state;

  otg_strobe_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .cs_n     (bus.otg_cs_n),
    .rd_n     (bus.otg_rd_n),
    .wr_n     (bus.otg_wr_n),
    .wr_act   (wr_act),
    .rd_rise  (rd_rise),
    .rd_fall  (rd_fall),
    .wr_fall  (wr_fall),
    .conflict (conflict)
  );

  assign wide        = is_wide(index_q, WIDE_LIMIT);
  assign rd_cmd      = bus.otg_addr[ADDR_CMD_BIT];
  assign rd_in_state = (state_q == S_RD_LO)
                     | (state_q == S_RD_HI);
  assign rd_good     = ~rd_cmd & rd_in_state
                     & (bus.otg_addr[ADDR_UNIT_BIT] == unit_q);
  assign rd_bad      = ~rd_cmd & ~rd_good;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    unit_d     = unit_q;
    index_d    = index_q;
    shadow_d   = shadow_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    err_d      = conflict;
    dout_d     = dout_q;
    oe_d       = oe_q;
    cap_addr_d = cap_addr_q;
    cap_data_d = cap_data_q;
    rd_ok_d    = rd_ok_q;

    if (wr_act) begin
      cap_addr_d = bus.otg_addr;
      cap_data_d = bus.otg_data_in;
    end

    if (state_q == S_FETCH && reg_rvalid) begin
      shadow_d = reg_rdata;
      state_d  = S_RD_LO;
    end

    // A command write wins over anything in flight.
    if (wr_fall) begin
      if (cap_addr_q[ADDR_CMD_BIT]) begin
        unit_d  = cap_addr_q[ADDR_UNIT_BIT];
        index_d = cap_data_q[6:0];
        if (cap_data_q[CMD_DIR_BIT]) begin
          state_d = S_WR_LO;
        end else begin
          re_d    = 1'b1;
          state_d = S_FETCH;
        end
      end else if (cap_addr_q[ADDR_UNIT_BIT] != unit_q) begin
        err_d = 1'b1;
      end else begin
        case (state_q)
          S_WR_LO: begin
            shadow_d[15:0] = cap_data_q;
            if (wide) begin
              state_d = S_WR_HI;
            end else begin
              we_d    = 1'b1;
              wdata_d = {16'h0000, cap_data_q};
              state_d = S_IDLE;
            end
          end
          S_WR_HI: begin
            shadow_d[31:16] = cap_data_q;
            we_d    = 1'b1;
            wdata_d = {cap_data_q, shadow_q[15:0]};
            state_d = S_IDLE;
          end
          default: err_d = 1'b1;
        endcase
      end
    end

    if (rd_rise) begin
      oe_d = 1'b1;
      unique case (1'b1)
        rd_cmd: begin
          dout_d  = CHIP_ID;
          rd_ok_d = 1'b0;
        end
        rd_good: begin
          dout_d  = (state_q == S_RD_LO) ? shadow_q[15:0]
                                         : shadow_q[31:16];
          rd_ok_d = 1'b1;
        end
        rd_bad: begin
          dout_d  = ERR_RDATA;
          rd_ok_d = 1'b0;
          err_d   = 1'b1;
        end
      endcase
    end

    if (rd_fall) begin
      oe_d    = 1'b0;
      rd_ok_d = 1'b0;
      if (rd_ok_q) begin
        case (state_q)
          S_RD_LO: state_d = wide ? S_RD_HI : S_IDLE;
          S_RD_HI: state_d = S_IDLE;
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      unit_q     <= 1'b0;
      index_q    <= 7'h00;
      shadow_q   <= 32'h0;
      wdata_q    <= 32'h0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      err_q      <= 1'b0;
      dout_q     <= 16'h0;
      oe_q       <= 1'b0;
      cap_addr_q <= 2'b00;
      cap_data_q <= 16'h0;
      rd_ok_q    <= 1'b0;
      int0_q     <= INT_ACTIVE_LOW;
      int1_q     <= INT_ACTIVE_LOW;
    end else begin
      unit_q     <= unit_d;
      index_q    <= index_d;
      shadow_q   <= shadow_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      err_q      <= err_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      cap_addr_q <= cap_addr_d;
      cap_data_q <= cap_data_d;
      rd_ok_q    <= rd_ok_d;
      int0_q     <= irq_hc ^ INT_ACTIVE_LOW;
      int1_q     <= irq_dc ^ INT_ACTIVE_LOW;
    end
  end

  assign bus.otg_data_out = dout_q;
  assign bus.otg_data_oe  = oe_q;
  assign otg_int0         = int0_q;
  assign otg_int1         = int1_q;
  assign reg_unit         = unit_q;
  assign reg_index        = index_q;
  assign reg_we           = we_q;
  assign reg_wdata        = wdata_q;
  assign reg_re           = re_q;
  assign err              = err_q;

endmodule

// File: tb/tb_otg_bus_responder.sv
// Directed bench for otg_bus_responder: a table of bus cycles with
// hand-computed results, plus reset-mid-read and interrupt sequences.
module tb_otg_bus_responder;

  localparam int HOLD = 6;
  localparam int GAP  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        otg_int0, otg_int1;
  logic        reg_unit;
  logic [6:0]  reg_index;
  logic        reg_we;
  logic [31:0] reg_wdata;
  logic        reg_re;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;
  logic        irq_hc, irq_dc;
  logic        err;

  logic [2:0]  re_pipe = 3'b000;
  logic [31:0] rsp_data;

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt   = 0;
  int re_cnt   = 0;
  int err_cnt  = 0;
  logic [31:0] last_wdata;
  logic        last_unit;
  logic [6:0]  last_index;

  always #5 clk = ~clk;

  otg_bus_responder_if bus ();

  otg_bus_responder #(
    .WIDE_LIMIT     (7'h20),
    .CHIP_ID        (16'h3630),
    .INT_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .otg_int0   (otg_int0),
    .otg_int1   (otg_int1),
    .reg_unit   (reg_unit),
    .reg_index  (reg_index),
    .reg_we     (reg_we),
    .reg_wdata  (reg_wdata),
    .reg_re     (reg_re),
    .reg_rdata  (reg_rdata),
    .reg_rvalid (reg_rvalid),
    .irq_hc     (irq_hc),
    .irq_dc     (irq_dc),
    .err        (err)
  );

  // Register file model: answers each read request 3 cycles later.
  always @(posedge clk) re_pipe <= {re_pipe[1:0], reg_re};
  assign reg_rvalid = re_pipe[2];
  assign reg_rdata  = rsp_data;

  always @(negedge clk) begin
    if (reg_we) begin
      we_cnt     = we_cnt + 1;
      last_wdata = reg_wdata;
      last_unit  = reg_unit;
      last_index = reg_index;
    end
    if (reg_re) re_cnt = re_cnt + 1;
    if (err) err_cnt = err_cnt + 1;
  end

  typedef struct {
    string       name;
    bit          rd;
    logic [1:0]  addr;
    logic [15:0] data;
    logic [15:0] exp_rd;
    int          d_we;
    int          d_re;
    int          d_err;
    logic [31:0] exp_wdata;
    logic        exp_unit;
    logic [6:0]  exp_index;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input bit rd,
                     input logic [1:0] a, input logic [15:0] d,
                     input logic [15:0] er, input int dwe,
                     input int dre, input int derr,
                     input logic [31:0] wd, input logic u,
                     input logic [6:0] ix);
    vec_t v;
    v.name = n; v.rd = rd; v.addr = a; v.data = d;
    v.exp_rd = er; v.d_we = dwe; v.d_re = dre; v.d_err = derr;
    v.exp_wdata = wd; v.exp_unit = u; v.exp_index = ix;
    tbl.push_back(v);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [15:0] d);
    bus.otg_addr    = a;
    bus.otg_data_in = d;
    bus.otg_cs_n    = 1'b0;
    bus.otg_wr_n    = 1'b0;
    repeat (HOLD) @(negedge clk);
    bus.otg_cs_n = 1'b1;
    bus.otg_wr_n = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic do_read(input logic [1:0] a, output logic [15:0] d,
                         output logic oe_mid, output logic oe_after);
    bus.otg_addr = a;
    bus.otg_cs_n = 1'b0;
    bus.otg_rd_n = 1'b0;
    repeat (HOLD - 1) @(negedge clk);
    d      = bus.otg_data_out;
    oe_mid = bus.otg_data_oe;
    @(negedge clk);
    bus.otg_cs_n = 1'b1;
    bus.otg_rd_n = 1'b1;
    repeat (GAP) @(negedge clk);
    oe_after = bus.otg_data_oe;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd;
    logic        oe_mid, oe_after;
    int          we0, re0, err0;

    reset           = 1'b1;
    irq_hc          = 1'b0;
    irq_dc          = 1'b0;
    rsp_data        = 32'hCAFEBABE;
    bus.otg_cs_n    = 1'b1;
    bus.otg_rd_n    = 1'b1;
    bus.otg_wr_n    = 1'b1;
    bus.otg_addr    = 2'b00;
    bus.otg_data_in = 16'h0000;
    repeat (4) @(negedge clk);

    check("reset_oe", bus.otg_data_oe, 0);
    check("reset_dout", bus.otg_data_out, 0);
    check("reset_pulses", {reg_we, reg_re, err}, 0);
    check("reset_reg", {reg_unit, reg_index}, 0);
    check("reset_wdata", reg_wdata, 0);
    check("reset_int", {otg_int0, otg_int1}, 2'b11);

    reset = 1'b0;
    repeat (2) @(negedge clk);

    //  name        rd addr  data      exp_rd  we re er  wdata      u  idx
    add("cmd_w05",   0, 2'd1, 16'h0085, 16'h0, 0, 0, 0, 32'h0, 0, 7'h00);
    add("wr_lo",     0, 2'd0, 16'h1234, 16'h0, 0, 0, 0, 32'h0, 0, 7'h00);
    add("wr_hi",     0, 2'd0, 16'hABCD, 16'h0, 1, 0, 0,
        32'hABCD1234, 0, 7'h05);
    add("cmd_r05",   0, 2'd1, 16'h0005, 16'h0, 0, 1, 0, 32'h0, 0, 7'h00);
    add("rd_lo",     1, 2'd0, 16'h0, 16'hBABE, 0, 0, 0, 32'h0, 0, 7'h00);
    add("wr_in_rd",  0, 2'd0, 16'h4444, 16'h0, 0, 0, 1, 32'h0, 0, 7'h00);
    add("rd_hi",     1, 2'd0, 16'h0, 16'hCAFE, 0, 0, 0, 32'h0, 0, 7'h00);
    add("cmd_dc24",  0, 2'd3, 16'h00A4, 16'h0, 0, 0, 0, 32'h0, 0, 7'h00);
    add("wr_narrow", 0, 2'd2, 16'h5555, 16'h0, 1, 0, 0,
        32'h00005555, 1, 7'h24);
    add("rd_idle",   1, 2'd2, 16'h0, 16'hFFFF, 0, 0, 1, 32'h0, 0, 7'h00);
    add("cmd_w01",   0, 2'd1, 16'h0081, 16'h0, 0, 0, 0, 32'h0, 0, 7'h00);
    add("wr_unit",   0, 2'd2, 16'h9999, 16'h0, 0, 0, 1, 32'h0, 0, 7'h00);
    add("wr_lo2",    0, 2'd0, 16'h1111, 16'h0, 0, 0, 0, 32'h0, 0, 7'h00);
    add("wr_hi2",    0, 2'd0, 16'h2222, 16'h0, 1, 0, 0,
        32'h22221111, 0, 7'h01);
    add("cmd_w05b",  0, 2'd1, 16'h0085, 16'h0, 0, 0, 0, 32'h0, 0, 7'h00);
    add("rd_in_wr",  1, 2'd0, 16'h0, 16'hFFFF, 0, 0, 1, 32'h0, 0, 7'h00);
    add("wr_lo3",    0, 2'd0, 16'h7777, 16'h0, 0, 0, 0, 32'h0, 0, 7'h00);
    add("abort_cmd", 0, 2'd1, 16'h0086, 16'h0, 0, 0, 0, 32'h0, 0, 7'h00);
    add("wr_lo4",    0, 2'd0, 16'h0001, 16'h0, 0, 0, 0, 32'h0, 0, 7'h00);
    add("wr_hi4",    0, 2'd0, 16'h0002, 16'h0, 1, 0, 0,
        32'h00020001, 0, 7'h06);
    add("chip_hc",   1, 2'd1, 16'h0, 16'h3630, 0, 0, 0, 32'h0, 0, 7'h00);
    add("chip_dc",   1, 2'd3, 16'h0, 16'h3630, 0, 0, 0, 32'h0, 0, 7'h00);

    foreach (tbl[i]) begin
      we0  = we_cnt;
      re0  = re_cnt;
      err0 = err_cnt;
      if (tbl[i].rd) begin
        do_read(tbl[i].addr, rd, oe_mid, oe_after);
        check({tbl[i].name, "_data"}, rd, tbl[i].exp_rd);
        check({tbl[i].name, "_oe"}, {oe_mid, oe_after}, 2'b10);
      end else begin
        do_write(tbl[i].addr, tbl[i].data);
      end
      check({tbl[i].name, "_pulses"},
            {8'(we_cnt - we0), 8'(re_cnt - re0), 8'(err_cnt - err0)},
            {8'(tbl[i].d_we), 8'(tbl[i].d_re), 8'(tbl[i].d_err)});
      if (tbl[i].d_we != 0)
        check({tbl[i].name, "_we"},
              {last_unit, last_index, last_wdata},
              {tbl[i].exp_unit, tbl[i].exp_index, tbl[i].exp_wdata});
    end

    // Reset while a low-half read is being driven.
    rsp_data = 32'h13572468;
    do_write(2'd1, 16'h0005);
    we0 = we_cnt;
    bus.otg_addr = 2'd0;
    bus.otg_cs_n = 1'b0;
    bus.otg_rd_n = 1'b0;
    repeat (4) @(negedge clk);
    check("midrd_pre", {bus.otg_data_oe, bus.otg_data_out},
          {1'b1, 16'h2468});
    reset        = 1'b1;
    bus.otg_cs_n = 1'b1;
    bus.otg_rd_n = 1'b1;
    @(negedge clk);
    check("midrd_oe", bus.otg_data_oe, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrd_reg", {reg_unit, reg_index}, 0);
    err0 = err_cnt;
    do_read(2'd0, rd, oe_mid, oe_after);
    check("midrd_idle", rd, 16'hFFFF);
    check("midrd_err", err_cnt - err0, 1);
    check("midrd_nowe", we_cnt - we0, 0);

    // Interrupt pins: active-low, one register of latency.
    @(negedge clk);
    check("int_idle", {otg_int0, otg_int1}, 2'b11);
    irq_hc = 1'b1;
    @(negedge clk);
    check("int0_act", {otg_int0, otg_int1}, 2'b01);
    irq_dc = 1'b1;
    check("int1_lat", otg_int1, 1);
    @(negedge clk);
    check("int1_act", {otg_int0, otg_int1}, 2'b00);
    irq_hc = 1'b0;
    @(negedge clk);
    check("int0_rel", {otg_int0, otg_int1}, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
